// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, byte-order helper and sequencer FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Byte 0 is the MSB, so byte idx starts at bit 120 - 8*idx.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inverse_sbox.sv
// ============================================================================
// Module      : inverse_sbox
// Description : Combinational AES inverse S-box (one byte in, one byte out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inverse_sbox
    import aes_pkg::*;
(
    input  byte_t byte_i,
    output byte_t byte_o
);

    // Entry x sits at bits [2047-8x -: 8], i.e. at lsb 8*(255-x).
    localparam logic [2047:0] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign byte_o = C_INV_SBOX[{~byte_i, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/inv_subbytes_seq.sv
// ============================================================================
// Module      : inv_subbytes_seq
// Description : InvSubBytes over a 128-bit state, LANES bytes per cycle,
//               valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   in_valid,
    output logic   in_ready,
    input  state_t in_state,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state,
    output logic   busy
);

    localparam int            NCHUNK = AES_BYTES / LANES;
    localparam int            CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
        $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t          state_q;
    logic [CW-1:0] cnt_q;
    state_t        work_q;
    state_t        work_d;
    logic          out_valid_q;
    logic          busy_q;
    logic          armed_q;
    logic          accept;

    byte_t         lane_in  [LANES];
    byte_t         lane_out [LANES];
    logic [6:0]    lane_lsb [LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [3:0] idx;
        assign idx         = 4'(32'(cnt_q) * LANES + j);
        assign lane_lsb[j] = byte_lsb(idx);
        assign lane_in[j]  = work_q[lane_lsb[j] +: 8];

        inverse_sbox u_inv_sbox (
            .byte_i (lane_in[j]),
            .byte_o (lane_out[j])
        );
    end

    always_comb begin
        work_d = work_q;
        for (int j = 0; j < LANES; j++) begin
            work_d[lane_lsb[j] +: 8] = lane_out[j];
        end
    end

    // armed_q keeps in_ready low while rst is held and until the first edge after.
    assign in_ready  = armed_q && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = work_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (clear) begin
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            work_q  <= in_state;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        work_q <= work_d;
                        if (cnt_q == C_LAST) begin
                            cnt_q       <= '0;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            if (accept) begin
                                work_q  <= in_state;
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= ST_BUSY;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inv_subbytes_seq.sv
// ============================================================================
// Module      : tb_inv_subbytes_seq
// Description : Directed bench for inv_subbytes_seq; LANES 1,2,4,8,16 side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_subbytes_seq;

    localparam int M = 2;  // instance index with LANES = 4

    localparam logic [127:0] C_V63  = 128'h63636363_63636363_63636363_63636363;
    localparam logic [127:0] C_V2   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] C_E2   = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;
    localparam logic [127:0] C_VFF  = {16{8'hff}};
    localparam logic [127:0] C_E7D  = {16{8'h7d}};

    logic         clk = 1'b0;
    logic         rst;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;

    logic         ov [5];
    logic         ir [5];
    logic         bz [5];
    logic [127:0] os [5];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_subbytes_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_state  (in_state),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_state (os[g]),
            .busy      (bz[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        tick();
        tick();
    endtask

    // One state through the LANES=4 instance with out_ready high.
    task automatic send_wait(input logic [127:0] s, output int lat,
                             output logic [127:0] res, output int busy_cnt);
        in_state  = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        lat       = -1;
        res       = '0;
        busy_cnt  = bz[M] ? 1 : 0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            tick();
            if (ov[M]) begin
                lat = i;
                res = os[M];
            end else if (bz[M]) begin
                busy_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        tick();
        tick();
        n_vec++; if (ov[M] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", ov[M]); end
        n_vec++; if (bz[M] !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", bz[M]); end
        n_vec++; if (ir[M] !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", ir[M]); end
        n_vec++; if (os[M] !== 128'h0) begin n_err++; $display("FAIL reset_out_state got=%h want=0", os[M]); end
        #2 rst = 1'b0;
        tick();
        tick();
        n_vec++; if (ir[M] !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got=%b want=1", ir[M]); end
        n_vec++; if (ov[M] !== 1'b0) begin n_err++; $display("FAIL idle_out_valid got=%b want=0", ov[M]); end
        n_vec++; if (bz[M] !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b want=0", bz[M]); end
    endtask

    task automatic test_latency();
        int lat; int bc; logic [127:0] res;
        send_wait(C_V63, lat, res, bc);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL lat63 got=%0d want=4", lat); end
        n_vec++; if (bc !== 4) begin n_err++; $display("FAIL busy63 got=%0d want=4", bc); end
        n_vec++; if (res !== 128'h0) begin n_err++; $display("FAIL out63 got=%h want=0", res); end
        tick();
    endtask

    task automatic test_vector();
        int lat; int bc; logic [127:0] res;
        send_wait(C_V2, lat, res, bc);
        n_vec++; if (res !== C_E2) begin n_err++; $display("FAIL vec2 got=%h want=%h", res, C_E2); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL vec2_lat got=%0d want=4", lat); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        in_state = C_V2; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick();
            if (ov[M]) lat = i;
        end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL bp_lat got=%0d want=4", lat); end
        for (int i = 0; i < 10; i++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            tick();
            n_vec++; if (os[M] !== C_E2) begin n_err++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, os[M], C_E2); end
            n_vec++; if (ov[M] !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got=%b want=1", i, ov[M]); end
            n_vec++; if (ir[M] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, ir[M]); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_vec++; if (ov[M] !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b want=0", ov[M]); end
    endtask

    task automatic test_back_to_back();
        int t [2]; logic [127:0] r [2]; int nres;
        nres = 0; t[0] = 0; t[1] = 0; r[0] = '0; r[1] = '0;
        in_state = C_V63; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_state = C_VFF;
        for (int i = 1; i <= 30 && nres < 2; i++) begin
            tick();
            if (ov[M]) begin
                t[nres] = i;
                r[nres] = os[M];
                nres++;
            end else if (nres == 1) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_vec++; if (nres !== 2) begin n_err++; $display("FAIL b2b_count got=%0d want=2", nres); end
        n_vec++; if (t[0] !== 4) begin n_err++; $display("FAIL b2b_first_lat got=%0d want=4", t[0]); end
        n_vec++; if (t[1] - t[0] !== 5) begin n_err++; $display("FAIL b2b_spacing got=%0d want=5", t[1] - t[0]); end
        n_vec++; if (r[0] !== 128'h0) begin n_err++; $display("FAIL b2b_res0 got=%h want=0", r[0]); end
        n_vec++; if (r[1] !== C_E7D) begin n_err++; $display("FAIL b2b_res1 got=%h want=%h", r[1], C_E7D); end
        tick();
    endtask

    task automatic test_clear();
        int lat; int bc; logic [127:0] res; bit seen;
        in_state = C_V2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clear = 1'b1; in_valid = 1'b1; in_state = C_VFF;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_vec++; if (bz[M] !== 1'b0) begin n_err++; $display("FAIL clr_busy got=%b want=0", bz[M]); end
        n_vec++; if (ov[M] !== 1'b0) begin n_err++; $display("FAIL clr_valid got=%b want=0", ov[M]); end
        n_vec++; if (ir[M] !== 1'b1) begin n_err++; $display("FAIL clr_idle_ready got=%b want=1", ir[M]); end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov[M] !== 1'b0) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL clr_no_output got=%b want=0", seen); end
        send_wait(C_VFF, lat, res, bc);
        n_vec++; if (res !== C_E7D) begin n_err++; $display("FAIL clr_next got=%h want=%h", res, C_E7D); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL clr_next_lat got=%0d want=4", lat); end
        tick();
    endtask

    task automatic test_async_rst();
        int lat; int bc; logic [127:0] res;
        in_state = C_V2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++; if (bz[M] !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy got=%b want=1", bz[M]); end
        #3 rst = 1'b1;
        #1;
        n_vec++; if (ov[M] !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b want=0", ov[M]); end
        n_vec++; if (bz[M] !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b want=0", bz[M]); end
        n_vec++; if (ir[M] !== 1'b0) begin n_err++; $display("FAIL arst_in_ready got=%b want=0", ir[M]); end
        n_vec++; if (os[M] !== 128'h0) begin n_err++; $display("FAIL arst_out_state got=%h want=0", os[M]); end
        tick();
        #2 rst = 1'b0;
        tick();
        tick();
        send_wait(C_V2, lat, res, bc);
        n_vec++; if (res !== C_E2) begin n_err++; $display("FAIL arst_rerun got=%h want=%h", res, C_E2); end
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL arst_rerun_lat got=%0d want=4", lat); end
        tick();
    endtask

    task automatic test_lanes_sweep();
        int lat [5]; logic [127:0] res [5];
        for (int g = 0; g < 5; g++) begin
            lat[g] = -1;
            res[g] = '0;
        end
        do_reset();
        in_state = C_V2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            for (int g = 0; g < 5; g++) begin
                if (ov[g] && lat[g] < 0) begin
                    lat[g] = i;
                    res[g] = os[g];
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            n_vec++; if (lat[g] !== (16 >> g)) begin n_err++; $display("FAIL sweep_lat_lanes%0d got=%0d want=%0d", 1 << g, lat[g], 16 >> g); end
            n_vec++; if (res[g] !== C_E2) begin n_err++; $display("FAIL sweep_out_lanes%0d got=%h want=%h", 1 << g, res[g], C_E2); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_vector();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_rst();
        test_lanes_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
